// File: rtl/alu_seq.sv
// Sequential integer ALU with a valid/ready handshake, iterative shift-add multiply
// and restoring unsigned divide. It runs one operation at a time and holds each result until it is taken.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_zero,
  output logic             out_dbz,
  output logic             out_illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_CMP  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic               r_zero;
  logic               r_dbz;
  logic               r_illegal;

  logic               w_accept;
  logic               w_isDiv;
  logic               w_iterative;
  logic               w_bigShift;
  logic [SW-1:0]      w_shamt;
  logic [WIDTH-1:0]   w_fastResult;
  logic [WIDTH-1:0]   w_fastHi;
  logic               w_fastDbz;
  logic               w_fastIllegal;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_divShift;
  logic [WIDTH:0]     w_divDiff;
  logic [2*WIDTH-1:0] w_accNext;
  logic [WIDTH-1:0]   w_iterResult;
  logic [WIDTH-1:0]   w_iterHi;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_result  = r_result;
  assign out_hi      = r_hi;
  assign out_zero    = r_zero;
  assign out_dbz     = r_dbz;
  assign out_illegal = r_illegal;

  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_isDiv     = (in_op == OP_DIVU) || (in_op == OP_REMU);
  assign w_iterative = (in_op == OP_MUL) || (w_isDiv && (in_b != '0));
  assign w_shamt     = in_b[SW-1:0];
  assign w_bigShift  = |in_b[WIDTH-1:SW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = w_iterative ? S_EXEC : S_DONE;
      S_EXEC:  if (r_cnt == LAST_ITER) w_nextState = S_DONE;
      S_DONE:  if (out_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Single-cycle results; DIVU/REMU only reach this path with a zero divisor.
  always_comb begin
    w_fastResult  = '0;
    w_fastHi      = '0;
    w_fastDbz     = 1'b0;
    w_fastIllegal = 1'b0;
    case (in_op)
      OP_ADD: w_fastResult = in_a + in_b;
      OP_SUB: w_fastResult = in_a - in_b;
      OP_SLL: w_fastResult = w_bigShift ? '0 : (in_a << w_shamt);
      OP_SRL: w_fastResult = w_bigShift ? '0 : (in_a >> w_shamt);
      OP_SRA: w_fastResult = w_bigShift ? {WIDTH{in_a[WIDTH-1]}}
                                        : $unsigned($signed(in_a) >>> w_shamt);
      OP_CMP: begin
        if ($signed(in_a) < $signed(in_b))      w_fastResult = WIDTH'(1);
        else if ($signed(in_a) > $signed(in_b)) w_fastResult = WIDTH'(2);
      end
      OP_DIVU: begin
        w_fastResult = '1;
        w_fastHi     = in_a;
        w_fastDbz    = 1'b1;
      end
      OP_REMU: begin
        w_fastResult = in_a;
        w_fastHi     = '1;
        w_fastDbz    = 1'b1;
      end
      OP_MUL:  w_fastResult = '0;
      default: w_fastIllegal = 1'b1;
    endcase
  end

  // Accumulator holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for division.
  always_comb begin
    w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_divDiff  = w_divShift - {1'b0, r_b};
    if (r_op == OP_MUL)
      w_accNext = {w_mulSum, r_acc[WIDTH-1:1]};
    else if (!w_divDiff[WIDTH])
      w_accNext = {w_divDiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    else
      w_accNext = {w_divShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    if (r_op == OP_REMU) begin
      w_iterResult = w_accNext[2*WIDTH-1:WIDTH];
      w_iterHi     = w_accNext[WIDTH-1:0];
    end else begin
      w_iterResult = w_accNext[WIDTH-1:0];
      w_iterHi     = w_accNext[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_hi      <= '0;
      r_zero    <= 1'b0;
      r_dbz     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_op  <= in_op;
            r_cnt <= '0;
            r_acc <= {{WIDTH{1'b0}}, (in_op == OP_MUL) ? in_b : in_a};
            if (!w_iterative) begin
              r_result  <= w_fastResult;
              r_hi      <= w_fastHi;
              r_zero    <= (w_fastResult == '0);
              r_dbz     <= w_fastDbz;
              r_illegal <= w_fastIllegal;
            end
          end
        end
        S_EXEC: begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_result  <= w_iterResult;
            r_hi      <= w_iterHi;
            r_zero    <= (w_iterResult == '0);
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
          end
        end
        default: begin
          if (out_ready) r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32: hand-computed results, latencies,
// backpressure hold and mid-operation reset.
module tb_alu_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [3:0]       in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_hi;
  logic             out_zero;
  logic             out_dbz;
  logic             out_illegal;

  int checkCount = 0;
  int failCount  = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_hi(out_hi),
    .out_zero(out_zero), .out_dbz(out_dbz), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offers one operation and returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int waitCycles = 0;
    @(negedge clk);
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expectResult(input string tag, input int expCycle, input logic [31:0] expRes,
                              input logic [31:0] expHi, input logic expDbz, input logic expIll);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    checkOutput({tag, ".cycle"}, 64'(lat + 1), 64'(expCycle));
    checkOutput({tag, ".result"}, 64'(out_result), 64'(expRes));
    checkOutput({tag, ".hi"}, 64'(out_hi), 64'(expHi));
    checkOutput({tag, ".zero"}, 64'(out_zero), 64'(expRes == 32'd0));
    checkOutput({tag, ".dbz"}, 64'(out_dbz), 64'(expDbz));
    checkOutput({tag, ".illegal"}, 64'(out_illegal), 64'(expIll));
    checkOutput({tag, ".inReadyLow"}, 64'(in_ready), 64'd0);
  endtask

  task automatic handOff(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput({tag, ".validDrop"}, 64'(out_valid), 64'd0);
    checkOutput({tag, ".readyBack"}, 64'(in_ready), 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int expCycle, input logic [31:0] expRes, input logic [31:0] expHi,
                       input logic expDbz, input logic expIll);
    applyStimulus(op, a, b);
    expectResult(tag, expCycle, expRes, expHi, expDbz, expIll);
    handOff(tag);
  endtask

  initial begin
    int staleSeen;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.outValid", 64'(out_valid), 64'd0);
    checkOutput("reset.inReady", 64'(in_ready), 64'd1);
    checkOutput("reset.result", 64'(out_result), 64'd0);
    checkOutput("reset.zero", 64'(out_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("add",    4'b0000, 32'hFFFFFFFF, 32'd1,  1,  32'h0,        32'h0,        1'b0, 1'b0);
    runOp("sub",    4'b0001, 32'd3,        32'd5,  1,  32'hFFFFFFFE, 32'h0,        1'b0, 1'b0);
    runOp("mulBig", 4'b0010, 32'hFFFFFFFF, 32'd2,  33, 32'hFFFFFFFE, 32'h1,        1'b0, 1'b0);
    runOp("mul76",  4'b0010, 32'd7,        32'd6,  33, 32'd42,       32'h0,        1'b0, 1'b0);
    runOp("divu",   4'b1011, 32'd100,      32'd7,  33, 32'd14,       32'd2,        1'b0, 1'b0);
    runOp("remu",   4'b1100, 32'd100,      32'd7,  33, 32'd2,        32'd14,       1'b0, 1'b0);
    runOp("divu0",  4'b1011, 32'd5,        32'd0,  1,  32'hFFFFFFFF, 32'd5,        1'b1, 1'b0);
    runOp("remu0",  4'b1100, 32'd5,        32'd0,  1,  32'd5,        32'hFFFFFFFF, 1'b1, 1'b0);
    runOp("ill5",   4'b0101, 32'd9,        32'd3,  1,  32'h0,        32'h0,        1'b0, 1'b1);
    runOp("sra4",   4'b1010, 32'h80000000, 32'd4,  1,  32'hF8000000, 32'h0,        1'b0, 1'b0);
    runOp("sra40",  4'b1010, 32'h80000000, 32'd40, 1,  32'hFFFFFFFF, 32'h0,        1'b0, 1'b0);
    runOp("srl31",  4'b0100, 32'h80000000, 32'd31, 1,  32'h1,        32'h0,        1'b0, 1'b0);
    runOp("sll32",  4'b0011, 32'd1,        32'd32, 1,  32'h0,        32'h0,        1'b0, 1'b0);
    runOp("sll3",   4'b0011, 32'd1,        32'd3,  1,  32'h8,        32'h0,        1'b0, 1'b0);
    runOp("cmpLt",  4'b1001, 32'hFFFFFFFF, 32'd1,  1,  32'h1,        32'h0,        1'b0, 1'b0);
    runOp("cmpGt",  4'b1001, 32'd1,        32'hFFFFFFFF, 1, 32'h2,   32'h0,        1'b0, 1'b0);
    runOp("cmpEq",  4'b1001, 32'd77,       32'd77, 1,  32'h0,        32'h0,        1'b0, 1'b0);

    // Result must hold while the consumer stalls, and new offers must be ignored.
    applyStimulus(4'b1011, 32'd1000, 32'd9);
    expectResult("bp", 33, 32'd111, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 4'b0000;
      in_a     = $urandom;
      in_b     = $urandom;
      @(posedge clk);
      #1;
      checkOutput("bp.result", 64'(out_result), 64'd111);
      checkOutput("bp.hi", 64'(out_hi), 64'd1);
      checkOutput("bp.inReady", 64'(in_ready), 64'd0);
      checkOutput("bp.outValid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    handOff("bp");
    staleSeen = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (out_valid) staleSeen++;
    end
    checkOutput("bp.noExtraOp", 64'(staleSeen), 64'd0);

    // Reset in the middle of a multiply discards it.
    applyStimulus(4'b0010, 32'hFFFFFFFF, 32'd2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.outValid", 64'(out_valid), 64'd0);
    checkOutput("rst.result", 64'(out_result), 64'd0);
    checkOutput("rst.hi", 64'(out_hi), 64'd0);
    checkOutput("rst.inReady", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    staleSeen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) staleSeen++;
    end
    checkOutput("rst.noStale", 64'(staleSeen), 64'd0);
    checkOutput("rst.inReadyAfter", 64'(in_ready), 64'd1);
    runOp("postRst", 4'b0000, 32'd20, 32'd22, 1, 32'd42, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
